// File: rtl/uart_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_arbiter
// Brief    : Round-robin arbiter that serialises multi-byte commands, MSB byte
//            first, onto one valid/ready byte stream with an idle gap between.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int CMD_WIDTH  = 16,
    parameter int GAP_CYCLES = 16,
    localparam int c_ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
    input  logic [NUM_REQ-1:0]           req_vld,
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic [7:0]                   byte_data,
    output logic                         byte_vld,
    input  logic                         byte_rdy,
    output logic [c_ID_W-1:0]            grant_id,
    output logic                         busy
);

    localparam int c_NUM_BYTES = CMD_WIDTH / 8;
    localparam int c_CNT_W     = (c_NUM_BYTES > 1) ? $clog2(c_NUM_BYTES) : 1;
    localparam int c_GAP_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_BYTE = c_CNT_W'(c_NUM_BYTES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD  = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_ID_W-1:0]      r_ptr;
    logic [c_ID_W-1:0]      r_grant_id;
    logic [CMD_WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0]     r_byte_cnt;
    logic [c_GAP_W-1:0]     r_gap_cnt;
    logic [7:0]             r_byte_data;
    logic                   r_byte_vld;

    logic [c_ID_W-1:0]      w_winner;
    logic [c_ID_W-1:0]      w_idx;
    logic [c_ID_W-1:0]      w_ptr_next;
    logic                   w_found;
    logic                   w_accept;
    logic [CMD_WIDTH-1:0]   w_win_cmd;

    // Search starts at r_ptr and wraps; the first pending requester wins.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = c_ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_vld[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_ptr_next = c_ID_W'((int'(w_winner) + 1) % NUM_REQ);
    assign w_win_cmd  = req_cmd[int'(w_winner)*CMD_WIDTH +: CMD_WIDTH];
    assign w_accept   = (r_state == S_IDLE) && w_found;

    // The accept strobe is combinational, so it is also masked while reset is held.
    assign req_rdy   = (w_accept && !rst) ? (NUM_REQ'(1) << w_winner) : '0;
    assign byte_data = r_byte_data;
    assign byte_vld  = r_byte_vld;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_shift     <= '0;
            r_byte_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_byte_data <= '0;
            r_byte_vld  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_byte_data <= w_win_cmd[CMD_WIDTH-1 -: 8];
                        r_shift     <= w_win_cmd << 8;
                        r_byte_vld  <= 1'b1;
                        r_byte_cnt  <= '0;
                        r_grant_id  <= w_winner;
                        r_ptr       <= w_ptr_next;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_byte_vld && byte_rdy) begin
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_byte_vld <= 1'b0;
                            if (GAP_CYCLES == 0) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_gap_cnt <= c_GAP_LOAD;
                                r_state   <= S_GAP;
                            end
                        end else begin
                            r_byte_cnt  <= r_byte_cnt + 1'b1;
                            r_byte_data <= r_shift[CMD_WIDTH-1 -: 8];
                            r_shift     <= r_shift << 8;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_byte_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_arbiter
// Brief    : Directed self-checking bench; instance a is 4x16-bit with a 4-cycle
//            gap, instance b is a single 32-bit source with no gap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_arbiter;

    localparam int c_NR = 4;
    localparam int c_CW = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [c_NR*c_CW-1:0]   req_cmd;
    logic [c_NR-1:0]        req_vld;
    logic [c_NR-1:0]        req_rdy;
    logic [7:0]             byte_data;
    logic                   byte_vld;
    logic                   byte_rdy;
    logic [1:0]             grant_id;
    logic                   busy;

    logic [31:0]            b_req_cmd;
    logic [0:0]             b_req_vld;
    logic [0:0]             b_req_rdy;
    logic [7:0]             b_byte_data;
    logic                   b_byte_vld;
    logic                   b_byte_rdy;
    logic [0:0]             b_grant_id;
    logic                   b_busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    uart_cmd_arbiter #(.NUM_REQ(4), .CMD_WIDTH(16), .GAP_CYCLES(4)) u_dut_a (
        .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_vld(req_vld), .req_rdy(req_rdy),
        .byte_data(byte_data), .byte_vld(byte_vld), .byte_rdy(byte_rdy),
        .grant_id(grant_id), .busy(busy)
    );

    uart_cmd_arbiter #(.NUM_REQ(1), .CMD_WIDTH(32), .GAP_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_cmd(b_req_cmd), .req_vld(b_req_vld), .req_rdy(b_req_rdy),
        .byte_data(b_byte_data), .byte_vld(b_byte_vld), .byte_rdy(b_byte_rdy),
        .grant_id(b_grant_id), .busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0;
        b_req_vld = '0;
        step();
        step();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_vld = 4'b1111;
        b_req_vld = 1'b1;
        byte_rdy = 1'b1;
        b_byte_rdy = 1'b1;
        step();
        settle();
        n_vec++; if (req_rdy !== 4'b0000) begin n_err++; $display("FAIL reset_req_rdy: got %b want 0000", req_rdy); end
        n_vec++; if (byte_vld !== 1'b0) begin n_err++; $display("FAIL reset_byte_vld: got %b want 0", byte_vld); end
        n_vec++; if (byte_data !== 8'h00) begin n_err++; $display("FAIL reset_byte_data: got %h want 00", byte_data); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if ({b_req_rdy, b_byte_vld, b_busy} !== 3'b000) begin
            n_err++; $display("FAIL reset_b_outputs: got %b want 000", {b_req_rdy, b_byte_vld, b_busy});
        end
        req_vld = '0;
        b_req_vld = '0;
        step();
        rst = 1'b0;
        settle();
        n_vec++; if ({busy, req_rdy} !== 5'b0) begin n_err++; $display("FAIL reset_release_idle: got %b want 00000", {busy, req_rdy}); end
    endtask

    // T1: single 16-bit command, 4-cycle gap
    task automatic test_single();
        do_reset();
        byte_rdy = 1'b1;
        req_cmd = '0;
        req_cmd[15:0] = 16'hA55A;
        req_vld = 4'b0001;
        settle();
        n_vec++; if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL t1_accept: got %b want 0001", req_rdy); end
        step(); req_vld = 4'b0000; settle();
        n_vec++; if ({byte_vld, byte_data} !== 9'h1A5) begin n_err++; $display("FAIL t1_byte0: got %b/%h want 1/a5", byte_vld, byte_data); end
        n_vec++; if ({busy, grant_id} !== 3'b100) begin n_err++; $display("FAIL t1_busy_grant: got %b want 100", {busy, grant_id}); end
        step(); settle();
        n_vec++; if ({byte_vld, byte_data} !== 9'h15A) begin n_err++; $display("FAIL t1_byte1: got %b/%h want 1/5a", byte_vld, byte_data); end
        step(); req_vld = 4'b0001; settle();
        n_vec++; if ({busy, byte_vld, req_rdy} !== 6'b100000) begin
            n_err++; $display("FAIL t1_gap_start: got %b want 100000", {busy, byte_vld, req_rdy});
        end
        for (int i = 4; i <= 6; i++) begin
            step(); settle();
            n_vec++; if ({busy, req_rdy} !== 5'b10000) begin
                n_err++; $display("FAIL t1_gap_hold: cycle T+%0d got %b want 10000", i, {busy, req_rdy});
            end
        end
        step(); settle();
        n_vec++; if ({busy, req_rdy} !== 5'b00001) begin n_err++; $display("FAIL t1_gap_end: got %b want 00001", {busy, req_rdy}); end
        req_vld = 4'b0000;
        settle();
    endtask

    // T2: all four pending, round-robin with gaps
    task automatic test_round_robin();
        int         order[5] = '{0, 1, 2, 3, 0};
        int         last_t;
        int         w;
        logic [3:0] exp_oh;
        do_reset();
        byte_rdy = 1'b1;
        for (int i = 0; i < c_NR; i++) req_cmd[i*c_CW +: c_CW] = {8'h10 + 8'(i), 8'h20 + 8'(i)};
        req_vld = 4'b1111;
        settle();
        last_t = 0;
        for (int n = 0; n < 5; n++) begin
            w = 0;
            while (req_rdy === 4'b0000 && w < 20) begin step(); settle(); w++; end
            exp_oh = 4'b0001 << order[n];
            n_vec++; if (req_rdy !== exp_oh) begin n_err++; $display("FAIL t2_accept%0d: got %b want %b", n, req_rdy, exp_oh); end
            if (n > 0) begin
                n_vec++; if (cyc - last_t != 7) begin n_err++; $display("FAIL t2_spacing%0d: got %0d want 7", n, cyc - last_t); end
            end
            last_t = cyc;
            step(); settle();
            n_vec++; if (grant_id !== 2'(order[n])) begin n_err++; $display("FAIL t2_grant%0d: got %0d want %0d", n, grant_id, order[n]); end
            n_vec++; if (byte_data !== 8'h10 + 8'(order[n])) begin
                n_err++; $display("FAIL t2_first_byte%0d: got %h want %h", n, byte_data, 8'h10 + 8'(order[n]));
            end
        end
        req_vld = 4'b0000;
        for (int k = 0; k < 30 && busy; k++) begin step(); settle(); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t2_drain: busy got %b want 0", busy); end
    endtask

    // T3: byte_rdy low for 10 cycles on the first byte
    task automatic test_backpressure();
        do_reset();
        byte_rdy = 1'b0;
        req_cmd[15:0] = 16'h1234;
        req_vld = 4'b0001;
        settle();
        n_vec++; if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL t3_accept: got %b want 0001", req_rdy); end
        step(); req_vld = 4'b0000; req_cmd[15:0] = 16'hFFFF; settle();
        for (int i = 0; i < 10; i++) begin
            n_vec++; if ({byte_vld, byte_data} !== 9'h112) begin
                n_err++; $display("FAIL t3_stall%0d: got %b/%h want 1/12", i, byte_vld, byte_data);
            end
            step(); settle();
        end
        byte_rdy = 1'b1;
        settle();
        n_vec++; if ({byte_vld, byte_data} !== 9'h112) begin n_err++; $display("FAIL t3_release: got %b/%h want 1/12", byte_vld, byte_data); end
        step(); settle();
        n_vec++; if ({byte_vld, byte_data} !== 9'h134) begin n_err++; $display("FAIL t3_byte1: got %b/%h want 1/34", byte_vld, byte_data); end
        step(); settle();
        n_vec++; if ({busy, byte_vld} !== 2'b10) begin n_err++; $display("FAIL t3_done: got %b want 10", {busy, byte_vld}); end
        for (int k = 0; k < 30 && busy; k++) begin step(); settle(); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t3_drain: busy got %b want 0", busy); end
    endtask

    // T4: pointer wraps after a grant to requester 3
    task automatic test_wrap();
        int w;
        do_reset();
        byte_rdy = 1'b1;
        req_cmd = '0;
        req_cmd[15:0]  = 16'h0A0A;
        req_cmd[47:32] = 16'h2C2C;
        req_cmd[63:48] = 16'h3131;
        req_vld = 4'b1000;
        settle();
        n_vec++; if (req_rdy !== 4'b1000) begin n_err++; $display("FAIL t4_accept3: got %b want 1000", req_rdy); end
        step(); req_vld = 4'b0101; settle();
        n_vec++; if ({grant_id, byte_data} !== 10'h331) begin n_err++; $display("FAIL t4_grant3: got %0d/%h want 3/31", grant_id, byte_data); end
        w = 0;
        while (req_rdy === 4'b0000 && w < 20) begin step(); settle(); w++; end
        n_vec++; if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL t4_wrap_to0: got %b want 0001", req_rdy); end
        step(); req_vld = 4'b0100; settle();
        n_vec++; if ({grant_id, byte_data} !== 10'h00A) begin n_err++; $display("FAIL t4_grant0: got %0d/%h want 0/0a", grant_id, byte_data); end
        w = 0;
        while (req_rdy === 4'b0000 && w < 20) begin step(); settle(); w++; end
        n_vec++; if (req_rdy !== 4'b0100) begin n_err++; $display("FAIL t4_then2: got %b want 0100", req_rdy); end
        step(); req_vld = 4'b0000; settle();
        n_vec++; if ({grant_id, byte_data} !== 10'h22C) begin n_err++; $display("FAIL t4_grant2: got %0d/%h want 2/2c", grant_id, byte_data); end
        for (int k = 0; k < 30 && busy; k++) begin step(); settle(); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t4_drain: busy got %b want 0", busy); end
    endtask

    // T5: asynchronous reset while the second byte is pending
    task automatic test_reset_abort();
        do_reset();
        byte_rdy = 1'b1;
        req_cmd = '0;
        req_cmd[15:0]  = 16'hBEEF;
        req_cmd[63:48] = 16'h3C3C;
        req_vld = 4'b0001;
        settle();
        n_vec++; if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL t5_accept: got %b want 0001", req_rdy); end
        step(); req_vld = 4'b0000; settle();
        n_vec++; if ({byte_vld, byte_data} !== 9'h1BE) begin n_err++; $display("FAIL t5_byte0: got %b/%h want 1/be", byte_vld, byte_data); end
        step(); byte_rdy = 1'b0; settle();
        n_vec++; if ({byte_vld, byte_data} !== 9'h1EF) begin n_err++; $display("FAIL t5_pending: got %b/%h want 1/ef", byte_vld, byte_data); end
        req_vld = 4'b1001;
        req_cmd[15:0] = 16'h5A6B;
        rst = 1'b1;
        settle();
        n_vec++; if ({byte_vld, busy, req_rdy, byte_data} !== 14'h0) begin
            n_err++; $display("FAIL t5_abort: got vld=%b busy=%b rdy=%b data=%h want all 0", byte_vld, busy, req_rdy, byte_data);
        end
        step(); step();
        byte_rdy = 1'b1;
        rst = 1'b0;
        settle();
        n_vec++; if (req_rdy !== 4'b0001) begin n_err++; $display("FAIL t5_ptr_reset: got %b want 0001", req_rdy); end
        step(); req_vld = 4'b0000; settle();
        n_vec++; if ({byte_vld, byte_data} !== 9'h15A) begin n_err++; $display("FAIL t5_new_byte0: got %b/%h want 1/5a", byte_vld, byte_data); end
        step(); settle();
        n_vec++; if ({byte_vld, byte_data} !== 9'h16B) begin n_err++; $display("FAIL t5_new_byte1: got %b/%h want 1/6b", byte_vld, byte_data); end
        for (int k = 0; k < 30 && busy; k++) begin step(); settle(); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL t5_drain: busy got %b want 0", busy); end
    endtask

    // T6: 32-bit command on a single-source, zero-gap instance; back-to-back accept
    task automatic test_back_to_back();
        logic [7:0] exp_b[4];
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        b_byte_rdy = 1'b1;
        b_req_cmd = 32'hDEADBEEF;
        b_req_vld = 1'b1;
        settle();
        n_vec++; if ({b_req_rdy, b_busy} !== 2'b10) begin n_err++; $display("FAIL t6_accept: got %b want 10", {b_req_rdy, b_busy}); end
        step(); b_req_cmd = 32'h01020304; settle();
        for (int i = 0; i < 4; i++) begin
            n_vec++; if ({b_byte_vld, b_byte_data} !== {1'b1, exp_b[i]}) begin
                n_err++; $display("FAIL t6_byte%0d: got %b/%h want 1/%h", i, b_byte_vld, b_byte_data, exp_b[i]);
            end
            step(); settle();
        end
        n_vec++; if ({b_req_rdy, b_busy, b_byte_vld, b_grant_id} !== 4'b1000) begin
            n_err++; $display("FAIL t6_nogap: got %b want 1000", {b_req_rdy, b_busy, b_byte_vld, b_grant_id});
        end
        step(); b_req_vld = 1'b0; settle();
        n_vec++; if ({b_byte_vld, b_byte_data} !== 9'h101) begin n_err++; $display("FAIL t6_next_cmd: got %b/%h want 1/01", b_byte_vld, b_byte_data); end
        for (int k = 0; k < 30 && b_busy; k++) begin step(); settle(); end
        n_vec++; if (b_busy !== 1'b0) begin n_err++; $display("FAIL t6_drain: busy got %b want 0", b_busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_cmd = '0;
        req_vld = '0;
        byte_rdy = 1'b0;
        b_req_cmd = '0;
        b_req_vld = '0;
        b_byte_rdy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
